// File: rtl/rv_regfile_mp_pkg.sv
// rv_pkg: shared constants for the multi-port RV32I register file.
//   DEF_XLEN    default register width
//   DEF_NREG    default register count
//   ZERO_IDX    index of the hard-wired zero register
//   addr_width  address width derived from a register count
package rv_pkg;

  localparam int DEF_XLEN = 32;
  localparam int DEF_NREG = 32;
  localparam int ZERO_IDX = 0;

  // A single-register file still needs a 1-bit address bus.
  function automatic int addr_width(input int nreg);
    return (nreg > 1) ? $clog2(nreg) : 1;
  endfunction

  localparam int DEF_AW = addr_width(DEF_NREG);

endpackage

// File: rtl/rv_regfile_mp_if.sv
// rv_regfile_mp_if: writeback, read, issue and scoreboard signals of the register file.
//   write A  : wa_we, wa_addr, wa_data   (ALU writeback)
//   write B  : wb_we, wb_addr, wb_data   (load writeback)
//   reads    : rd_addr (flattened NRD x AW), rd_data (flattened NRD x XLEN), rd_busy
//   issue    : iss_valid, iss_rd, flush
//   status   : busy_any
// Modports: slave = register file, master = pipeline side.
interface rv_regfile_mp_if
  import rv_pkg::*;
#(
  parameter int XLEN = DEF_XLEN,
  parameter int NREG = DEF_NREG,
  parameter int NRD  = 2
) ();

  localparam int AW = addr_width(NREG);

  logic                wa_we;
  logic [AW-1:0]       wa_addr;
  logic [XLEN-1:0]     wa_data;
  logic                wb_we;
  logic [AW-1:0]       wb_addr;
  logic [XLEN-1:0]     wb_data;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic                iss_valid;
  logic [AW-1:0]       iss_rd;
  logic                flush;
  logic                busy_any;

  modport slave (
    input  wa_we, wa_addr, wa_data, wb_we, wb_addr, wb_data,
    input  rd_addr, iss_valid, iss_rd, flush,
    output rd_data, rd_busy, busy_any
  );

  modport master (
    output wa_we, wa_addr, wa_data, wb_we, wb_addr, wb_data,
    output rd_addr, iss_valid, iss_rd, flush,
    input  rd_data, rd_busy, busy_any
  );

endinterface

// File: rtl/rv_regfile_mp_scoreboard.sv
// rv_scoreboard: pending-write busy bit per register.
//   sys_clk, sys_rst     clock, synchronous active-high reset
//   wa_we/wa_addr        write port A (clears busy)
//   wb_we/wb_addr        write port B (clears busy)
//   iss_valid/iss_rd     issuing destination (sets busy)
//   flush                clears every busy bit, ignores issue
//   busy                 registered busy vector
module rv_scoreboard
  import rv_pkg::*;
#(
  parameter int NREG     = DEF_NREG,
  parameter int ZERO_REG = 1,
  localparam int AW      = addr_width(NREG)
) (
  input  logic            sys_clk,
  input  logic            sys_rst,
  input  logic            wa_we,
  input  logic [AW-1:0]   wa_addr,
  input  logic            wb_we,
  input  logic [AW-1:0]   wb_addr,
  input  logic            iss_valid,
  input  logic [AW-1:0]   iss_rd,
  input  logic            flush,
  output logic [NREG-1:0] busy
);

  logic [NREG-1:0] busy_d;

  // Addresses at or beyond NREG never match a loop index, so they drop out.
  always_comb begin
    busy_d = busy;
    if (flush) begin
      busy_d = '0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        if ((wa_we && wa_addr == AW'(r)) || (wb_we && wb_addr == AW'(r)))
          busy_d[r] = 1'b0;
        // Applied after the clear: a freshly issued producer keeps the register busy.
        if (iss_valid && iss_rd == AW'(r) && !(ZERO_REG != 0 && r == ZERO_IDX))
          busy_d[r] = 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) busy <= '0;
    else         busy <= busy_d;
  end

endmodule

// File: rtl/rv_regfile_mp.sv
// rv_regfile_mp: NREG x XLEN register file, two write ports, NRD read ports,
// optional write-to-read bypass and a pending-write scoreboard.
//   sys_clk, sys_rst  clock, synchronous active-high reset
//   bus               rv_regfile_mp_if slave modport (writes, reads, issue, status)
// Parameters: XLEN, NREG, NRD, ZERO_REG (x0 hard-wired to 0), BYPASS.
module rv_regfile_mp
  import rv_pkg::*;
#(
  parameter int XLEN     = DEF_XLEN,
  parameter int NREG     = DEF_NREG,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  rv_regfile_mp_if.slave bus
);

  localparam int AW = addr_width(NREG);

  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] busy;

  rv_scoreboard #(
    .NREG     (NREG),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .wa_we     (bus.wa_we),
    .wa_addr   (bus.wa_addr),
    .wb_we     (bus.wb_we),
    .wb_addr   (bus.wb_addr),
    .iss_valid (bus.iss_valid),
    .iss_rd    (bus.iss_rd),
    .flush     (bus.flush),
    .busy      (busy)
  );

  // Port B is checked first so a load wins a same-address collision.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      for (int r = 0; r < NREG; r++) regs[r] <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        if (!(ZERO_REG != 0 && r == ZERO_IDX)) begin
          if (bus.wb_we && bus.wb_addr == AW'(r))      regs[r] <= bus.wb_data;
          else if (bus.wa_we && bus.wa_addr == AW'(r)) regs[r] <= bus.wa_data;
        end
      end
    end
  end

  assign bus.busy_any = |busy;

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] addr_k;
    logic          in_range;
    logic          is_zero;
    logic          hit_a;
    logic          hit_b;

    assign addr_k = bus.rd_addr[k*AW +: AW];

    if (NREG == (1 << AW)) begin : g_full
      assign in_range = 1'b1;
    end else begin : g_part
      assign in_range = (addr_k < AW'(NREG));
    end

    assign is_zero = (ZERO_REG != 0) && (addr_k == AW'(ZERO_IDX));
    assign hit_b   = (BYPASS != 0) && in_range && !is_zero && bus.wb_we && (bus.wb_addr == addr_k);
    assign hit_a   = (BYPASS != 0) && in_range && !is_zero && bus.wa_we && (bus.wa_addr == addr_k);

    always_comb begin
      bus.rd_data[k*XLEN +: XLEN] = '0;
      if (in_range && !is_zero) begin
        if (hit_b)      bus.rd_data[k*XLEN +: XLEN] = bus.wb_data;
        else if (hit_a) bus.rd_data[k*XLEN +: XLEN] = bus.wa_data;
        else            bus.rd_data[k*XLEN +: XLEN] = regs[addr_k];
      end
    end

    // A bypassed read already carries the producer's value, so it need not stall.
    assign bus.rd_busy[k] = in_range && busy[addr_k] && !(hit_a || hit_b);
  end

endmodule

// File: tb/tb_rv_regfile_mp.sv
module tb_rv_regfile_mp;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  // d0: default config; d1: no bypass; d2: 3 read ports, 16 regs, writable x0
  rv_regfile_mp_if #(.XLEN(32), .NREG(32), .NRD(2)) i0 ();
  rv_regfile_mp_if #(.XLEN(32), .NREG(32), .NRD(2)) i1 ();
  rv_regfile_mp_if #(.XLEN(32), .NREG(16), .NRD(3)) i2 ();

  rv_regfile_mp #(.XLEN(32), .NREG(32), .NRD(2), .ZERO_REG(1), .BYPASS(1))
    d0 (.sys_clk(clk), .sys_rst(rst), .bus(i0));
  rv_regfile_mp #(.XLEN(32), .NREG(32), .NRD(2), .ZERO_REG(1), .BYPASS(0))
    d1 (.sys_clk(clk), .sys_rst(rst), .bus(i1));
  rv_regfile_mp #(.XLEN(32), .NREG(16), .NRD(3), .ZERO_REG(0), .BYPASS(1))
    d2 (.sys_clk(clk), .sys_rst(rst), .bus(i2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    i0.wa_we = 0; i0.wb_we = 0; i0.iss_valid = 0; i0.flush = 0;
    i1.wa_we = 0; i1.wb_we = 0; i1.iss_valid = 0; i1.flush = 0;
    i2.wa_we = 0; i2.wb_we = 0; i2.iss_valid = 0; i2.flush = 0;
  endtask

  initial begin
    idle();
    i0.wa_addr = '0; i0.wa_data = '0; i0.wb_addr = '0; i0.wb_data = '0;
    i1.wa_addr = '0; i1.wa_data = '0; i1.wb_addr = '0; i1.wb_data = '0;
    i2.wa_addr = '0; i2.wa_data = '0; i2.wb_addr = '0; i2.wb_data = '0;
    i0.rd_addr = '0; i1.rd_addr = '0; i2.rd_addr = '0;
    i0.iss_rd = '0;  i1.iss_rd = '0;  i2.iss_rd = '0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_rd0", i0.rd_data[31:0], 32'h0);
    chk("rst_busy", {31'b0, i0.rd_busy[0]}, 32'h0);
    chk("rst_busy_any", {31'b0, i0.busy_any}, 32'h0);

    // ---------- reset clears a written register, overrides issue ----------
    i0.wa_we = 1; i0.wa_addr = 5; i0.wa_data = 32'hDEADBEEF;
    tick(); idle();
    i0.rd_addr = {5'd7, 5'd5};
    #1 chk("x5_written", i0.rd_data[31:0], 32'hDEADBEEF);
    rst = 1'b1; i0.iss_valid = 1; i0.iss_rd = 8;
    tick(); rst = 1'b0; idle();
    #1 chk("x5_after_rst", i0.rd_data[31:0], 32'h0);
    chk("busy_any_after_rst", {31'b0, i0.busy_any}, 32'h0);

    // ---------- bypass on port 1 ----------
    i0.wa_we = 1; i0.wa_addr = 7; i0.wa_data = 32'h12345678;
    #1 chk("byp_port1", i0.rd_data[63:32], 32'h12345678);
    chk("byp_port0_other", i0.rd_data[31:0], 32'h0);
    tick(); idle();
    #1 chk("x7_array", i0.rd_data[63:32], 32'h12345678);

    // ---------- zero register ----------
    i0.wa_we = 1; i0.wa_addr = 0; i0.wa_data = 32'hFFFF;
    i0.wb_we = 1; i0.wb_addr = 0; i0.wb_data = 32'hABCD;
    i0.rd_addr = {5'd0, 5'd0};
    #1 chk("x0_byp_p0", i0.rd_data[31:0], 32'h0);
    chk("x0_byp_p1", i0.rd_data[63:32], 32'h0);
    tick(); idle();
    #1 chk("x0_arr_p0", i0.rd_data[31:0], 32'h0);
    chk("x0_arr_p1", i0.rd_data[63:32], 32'h0);

    // ---------- dual write collision ----------
    i0.wa_we = 1; i0.wa_addr = 3; i0.wa_data = 32'h1111;
    i0.wb_we = 1; i0.wb_addr = 3; i0.wb_data = 32'h2222;
    i0.rd_addr = {5'd7, 5'd3};
    #1 chk("collide_byp", i0.rd_data[31:0], 32'h2222);
    tick(); idle();
    #1 chk("collide_arr", i0.rd_data[31:0], 32'h2222);

    // ---------- scoreboard lifecycle ----------
    i0.iss_valid = 1; i0.iss_rd = 9; i0.rd_addr = {5'd3, 5'd9};
    #1 chk("x9_not_yet_busy", {31'b0, i0.rd_busy[0]}, 32'h0);
    tick(); idle();
    #1 chk("x9_busy", {31'b0, i0.rd_busy[0]}, 32'h1);
    chk("x9_busy_any", {31'b0, i0.busy_any}, 32'h1);
    chk("x3_not_busy", {31'b0, i0.rd_busy[1]}, 32'h0);
    i0.wb_we = 1; i0.wb_addr = 9; i0.wb_data = 32'h55;
    #1 chk("x9_busy_bypassed", {31'b0, i0.rd_busy[0]}, 32'h0);
    chk("x9_byp_data", i0.rd_data[31:0], 32'h55);
    chk("x9_busy_any_reg", {31'b0, i0.busy_any}, 32'h1);
    tick(); idle();
    #1 chk("x9_cleared", {31'b0, i0.rd_busy[0]}, 32'h0);
    chk("x9_cleared_any", {31'b0, i0.busy_any}, 32'h0);
    chk("x9_data", i0.rd_data[31:0], 32'h55);

    // ---------- set wins over clear, then flush beats issue ----------
    i0.iss_valid = 1; i0.iss_rd = 4; i0.rd_addr = {5'd6, 5'd4};
    tick(); idle();
    i0.wa_we = 1; i0.wa_addr = 4; i0.wa_data = 32'h44;
    i0.iss_valid = 1; i0.iss_rd = 4;
    #1 chk("x4_busy_bypassed", {31'b0, i0.rd_busy[0]}, 32'h0);
    tick(); idle();
    #1 chk("x4_still_busy", {31'b0, i0.rd_busy[0]}, 32'h1);
    i0.flush = 1; i0.iss_valid = 1; i0.iss_rd = 6;
    tick(); idle();
    #1 chk("flush_any", {31'b0, i0.busy_any}, 32'h0);
    chk("flush_x4", {31'b0, i0.rd_busy[0]}, 32'h0);
    chk("flush_x6", {31'b0, i0.rd_busy[1]}, 32'h0);
    chk("x4_data", i0.rd_data[31:0], 32'h44);

    // ---------- issue to x0 never sets busy ----------
    i0.iss_valid = 1; i0.iss_rd = 0;
    tick(); idle();
    #1 chk("x0_issue_any", {31'b0, i0.busy_any}, 32'h0);

    // ---------- BYPASS=0 ----------
    i1.wa_we = 1; i1.wa_addr = 7; i1.wa_data = 32'h12345678; i1.rd_addr = {5'd7, 5'd9};
    #1 chk("nobyp_old", i1.rd_data[63:32], 32'h0);
    tick(); idle();
    #1 chk("nobyp_arr", i1.rd_data[63:32], 32'h12345678);
    i1.iss_valid = 1; i1.iss_rd = 9;
    tick(); idle();
    i1.wb_we = 1; i1.wb_addr = 9; i1.wb_data = 32'h55;
    #1 chk("nobyp_busy_wr", {31'b0, i1.rd_busy[0]}, 32'h1);
    chk("nobyp_data_wr", i1.rd_data[31:0], 32'h0);
    tick(); idle();
    #1 chk("nobyp_busy_after", {31'b0, i1.rd_busy[0]}, 32'h0);
    chk("nobyp_data_after", i1.rd_data[31:0], 32'h55);

    // ---------- NRD=3, NREG=16, ZERO_REG=0 ----------
    i2.wa_we = 1; i2.wa_addr = 0; i2.wa_data = 32'hA5; i2.rd_addr = {4'd0, 4'd5, 4'd0};
    #1 chk("d2_x0_byp", i2.rd_data[31:0], 32'hA5);
    tick(); idle();
    i2.wa_we = 1; i2.wa_addr = 1; i2.wa_data = 32'h11;
    i2.wb_we = 1; i2.wb_addr = 2; i2.wb_data = 32'h22;
    tick(); idle();
    i2.rd_addr = {4'd2, 4'd1, 4'd0};
    #1 chk("d2_p0_x0", i2.rd_data[31:0], 32'hA5);
    chk("d2_p1_x1", i2.rd_data[63:32], 32'h11);
    chk("d2_p2_x2", i2.rd_data[95:64], 32'h22);
    i2.rd_addr = {4'd1, 4'd0, 4'd2};
    #1 chk("d2_p0_x2", i2.rd_data[31:0], 32'h22);
    chk("d2_p1_x0", i2.rd_data[63:32], 32'hA5);
    chk("d2_p2_x1", i2.rd_data[95:64], 32'h11);
    chk("d2_idle_any", {31'b0, i2.busy_any}, 32'h0);
    i2.iss_valid = 1; i2.iss_rd = 15;
    tick(); idle();
    #1 chk("d2_any_x15", {31'b0, i2.busy_any}, 32'h1);
    i2.iss_valid = 1; i2.iss_rd = 0;
    tick(); idle();
    i2.rd_addr = {4'd15, 4'd1, 4'd0};
    #1 chk("d2_x0_busy", {29'b0, i2.rd_busy}, 32'h5);
    i2.wa_we = 1; i2.wa_addr = 15; i2.wa_data = 32'hF;
    tick(); idle();
    #1 chk("d2_any_x0_only", {31'b0, i2.busy_any}, 32'h1);
    chk("d2_busy_x0_only", {29'b0, i2.rd_busy}, 32'h1);
    i2.wb_we = 1; i2.wb_addr = 0; i2.wb_data = 32'h5A;
    tick(); idle();
    #1 chk("d2_any_clear", {31'b0, i2.busy_any}, 32'h0);
    chk("d2_x0_new", i2.rd_data[31:0], 32'h5A);
    chk("d2_x15_data", i2.rd_data[95:64], 32'hF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
